// File: rtl/render_pkg.sv
// Shared state encoding and clear constants for the render frame sequencer.
package render_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_READY,
    S_START,
    S_RUN,
    S_SWAP
  } seq_state_e;

  localparam int unsigned DEPTH_MAX_W = 32;

  // Far-plane depth; users slice it down to their configured depth width.
  localparam logic [DEPTH_MAX_W-1:0] CLEAR_DEPTH = '1;

  localparam int unsigned DEFAULT_CLEAR_COLOR = 0;

  function automatic int unsigned sat_count(input int unsigned req,
                                            input int unsigned ceiling);
    return (req > ceiling) ? ceiling : req;
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Clear-address generator: after a start pulse, sweeps 0..NUM_PIXELS-1 one
// address per cycle and flags the terminal address.
module fb_clear_engine #(
  parameter int ADDRWIDTH  = 17,
  parameter int NUM_PIXELS = 76800
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  output logic                 done_o,
  output logic                 wr_en_o,
  output logic [ADDRWIDTH-1:0] addr_o
);

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NUM_PIXELS - 1);

  logic                 running_q;
  logic [ADDRWIDTH-1:0] addr_q;

  assign done_o  = running_q && (addr_q == LAST_ADDR);
  assign wr_en_o = running_q;
  assign addr_o  = addr_q;

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      running_q <= 1'b0;
      addr_q    <= '0;
    end else if (start_i) begin
      running_q <= 1'b1;
      addr_q    <= '0;
    end else if (running_q) begin
      if (done_o) begin
        running_q <= 1'b0;
        addr_q    <= '0;
      end else begin
        addr_q <= addr_q + ADDRWIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/render_frame_sequencer.sv
// Frame-level sequencer: optional framebuffer clear, per-object pipeline
// handshake, buffer swap, and a registered framebuffer write port.
module render_frame_sequencer
  import render_pkg::*;
#(
  parameter int MAX_NUM_OBJECTS_PER_FRAME = 1024,
  parameter int SCREEN_WIDTH              = 320,
  parameter int SCREEN_HEIGHT             = 240,
  parameter int ADDRWIDTH                 = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
  parameter int OUTPUT_DATAWIDTH          = 12,
  parameter int COLORWIDTH                = 4,
  parameter int CLEAR_COLOR               = DEFAULT_CLEAR_COLOR,
  localparam int OBJW                     = $clog2(MAX_NUM_OBJECTS_PER_FRAME + 1),
  localparam int IDXW                     = $clog2(MAX_NUM_OBJECTS_PER_FRAME)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_frame_start,
  input  logic [OBJW-1:0]             i_object_count,
  input  logic                        i_clear_en,
  output logic                        o_busy,
  output logic                        o_frame_done,
  output logic                        o_frame_dropped,
  output logic [IDXW-1:0]             o_object_idx,
  output logic                        o_pipe_start,
  input  logic                        i_pipe_ready,
  input  logic                        i_pipe_finished,
  input  logic [ADDRWIDTH-1:0]        i_pipe_fb_addr,
  input  logic                        i_pipe_fb_write_en,
  input  logic [OUTPUT_DATAWIDTH-1:0] i_pipe_fb_depth_data,
  input  logic [COLORWIDTH-1:0]       i_pipe_fb_color_data,
  output logic [ADDRWIDTH-1:0]        o_fb_addr_write,
  output logic                        o_fb_write_en,
  output logic [OUTPUT_DATAWIDTH-1:0] o_fb_depth_data,
  output logic [COLORWIDTH-1:0]       o_fb_color_data,
  output logic                        o_swap_req,
  input  logic                        i_swap_ack
);

  localparam logic [OUTPUT_DATAWIDTH-1:0] CLR_DEPTH = CLEAR_DEPTH[OUTPUT_DATAWIDTH-1:0];
  localparam logic [COLORWIDTH-1:0]       CLR_COLOR = COLORWIDTH'(CLEAR_COLOR);

  seq_state_e       state_q;
  logic [OBJW-1:0]  count_q;
  logic [OBJW-1:0]  idx_q;
  logic [OBJW-1:0]  idx_d;
  logic [OBJW-1:0]  accept_count;
  logic             pipe_start_q;
  logic             swap_req_q;
  logic             frame_done_q;
  logic             dropped_q;

  logic                  clr_start;
  logic                  clr_done;
  logic                  clr_we;
  logic [ADDRWIDTH-1:0]  clr_addr;
  logic                  fwd_active;

  logic [ADDRWIDTH-1:0]        fb_addr_q;
  logic                        fb_we_q;
  logic [OUTPUT_DATAWIDTH-1:0] fb_depth_q;
  logic [COLORWIDTH-1:0]       fb_color_q;

  // Requests above the ceiling are clipped rather than rejected.
  assign accept_count = OBJW'(sat_count(32'(i_object_count),
                                        32'(MAX_NUM_OBJECTS_PER_FRAME)));
  assign clr_start    = (state_q == S_IDLE) && i_frame_start && i_clear_en;
  assign idx_d        = idx_q + OBJW'(1);
  assign fwd_active   = (state_q == S_WAIT_READY) || (state_q == S_START) ||
                        (state_q == S_RUN);

  fb_clear_engine #(
    .ADDRWIDTH  (ADDRWIDTH),
    .NUM_PIXELS (SCREEN_WIDTH * SCREEN_HEIGHT)
  ) u_clear (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (clr_start),
    .done_o  (clr_done),
    .wr_en_o (clr_we),
    .addr_o  (clr_addr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      pipe_start_q <= 1'b0;
      swap_req_q   <= 1'b0;
      frame_done_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      dropped_q    <= i_frame_start && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (i_frame_start) begin
            count_q <= accept_count;
            idx_q   <= '0;
            if (i_clear_en) begin
              state_q <= S_CLEAR;
            end else if (accept_count == '0) begin
              state_q    <= S_SWAP;
              swap_req_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_READY;
            end
          end
        end
        S_CLEAR: begin
          if (clr_done) begin
            if (count_q == '0) begin
              state_q    <= S_SWAP;
              swap_req_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_READY;
            end
          end
        end
        S_WAIT_READY: begin
          if (i_pipe_ready) begin
            state_q      <= S_START;
            pipe_start_q <= 1'b1;
          end
        end
        S_START: begin
          state_q      <= S_RUN;
          pipe_start_q <= 1'b0;
        end
        S_RUN: begin
          if (i_pipe_finished) begin
            idx_q <= idx_d;
            if (idx_d >= count_q) begin
              state_q    <= S_SWAP;
              swap_req_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_READY;
            end
          end
        end
        S_SWAP: begin
          if (i_swap_ack) begin
            state_q      <= S_IDLE;
            swap_req_q   <= 1'b0;
            frame_done_q <= 1'b1;
            idx_q        <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Single output register shared by both write sources keeps latency equal.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fb_addr_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_depth_q <= '0;
      fb_color_q <= '0;
    end else if (clr_we) begin
      fb_addr_q  <= clr_addr;
      fb_we_q    <= 1'b1;
      fb_depth_q <= CLR_DEPTH;
      fb_color_q <= CLR_COLOR;
    end else if (fwd_active) begin
      fb_addr_q  <= i_pipe_fb_addr;
      fb_we_q    <= i_pipe_fb_write_en;
      fb_depth_q <= i_pipe_fb_depth_data;
      fb_color_q <= i_pipe_fb_color_data;
    end else begin
      fb_addr_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_depth_q <= '0;
      fb_color_q <= '0;
    end
  end

  assign o_busy          = (state_q != S_IDLE);
  assign o_frame_done    = frame_done_q;
  assign o_frame_dropped = dropped_q;
  assign o_object_idx    = idx_q[IDXW-1:0];
  assign o_pipe_start    = pipe_start_q;
  assign o_swap_req      = swap_req_q;
  assign o_fb_addr_write = fb_addr_q;
  assign o_fb_write_en   = fb_we_q;
  assign o_fb_depth_data = fb_depth_q;
  assign o_fb_color_data = fb_color_q;

endmodule
